// File: rtl/reg_operand_wb_ctrl.sv
// rtl/reg_operand_wb_ctrl.sv - operand fetch / write-back controller around RegBank
// Optional feature macro: RF_ZERO_REG_EN (r0 reads as zero and is never write-enabled).
module reg_operand_wb_ctrl #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    issue_valid,
  output logic                    issue_ready,
  input  logic [ADDR_W-1:0]       issue_rdest,
  input  logic [ADDR_W-1:0]       issue_rsrc,
  input  logic                    issue_wb,
  input  logic [NREGS*DATA_W-1:0] regs_flat,
  output logic [DATA_W-1:0]       op_a,
  output logic [DATA_W-1:0]       op_b,
  output logic                    op_valid,
  input  logic                    op_ready,
  input  logic                    res_valid,
  input  logic [DATA_W-1:0]       res_data,
  output logic [DATA_W-1:0]       alu_bus,
  output logic [NREGS-1:0]        reg_enable,
  output logic [7:0]              wb_count
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_WAIT_RES, S_WB} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] rdest_q, rsrc_q;
  logic              wb_q;
  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] rd_a, rd_b;
  logic [NREGS-1:0]  wr_sel;

  for (genvar i = 0; i < NREGS; i++) begin : g_unflatten
    assign regs[i] = regs_flat[i*DATA_W +: DATA_W];
  end

`ifdef RF_ZERO_REG_EN
  assign rd_a   = (rdest_q == '0) ? '0 : regs[rdest_q];
  assign rd_b   = (rsrc_q  == '0) ? '0 : regs[rsrc_q];
  assign wr_sel = (rdest_q == '0) ? '0 : (NREGS'(1) << rdest_q);
`else
  assign rd_a   = regs[rdest_q];
  assign rd_b   = regs[rsrc_q];
  assign wr_sel = NREGS'(1) << rdest_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:     if (issue_valid) state_nx = S_FETCH;
      S_FETCH:    state_nx = S_ISSUE;
      S_ISSUE:    if (op_ready) state_nx = S_WAIT_RES;
      S_WAIT_RES: if (res_valid) state_nx = wb_q ? S_WB : S_IDLE;
      S_WB:       state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    issue_ready = (state == S_IDLE);
  end

  // Registered datapath; reset discards any in-flight instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdest_q    <= '0;
      rsrc_q     <= '0;
      wb_q       <= 1'b0;
      op_a       <= '0;
      op_b       <= '0;
      op_valid   <= 1'b0;
      alu_bus    <= '0;
      reg_enable <= '0;
      wb_count   <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          if (issue_valid) begin
            rdest_q <= issue_rdest;
            rsrc_q  <= issue_rsrc;
            wb_q    <= issue_wb;
          end
        end
        S_FETCH: begin
          op_a     <= rd_a;
          op_b     <= rd_b;
          op_valid <= 1'b1;
        end
        S_ISSUE: begin
          if (op_ready) op_valid <= 1'b0;
        end
        S_WAIT_RES: begin
          if (res_valid && wb_q) begin
            alu_bus    <= res_data;
            reg_enable <= wr_sel;
          end
        end
        S_WB: begin
          reg_enable <= '0;
          wb_count   <= wb_count + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
